// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: digit-serial two's-complement add/sub, DIGIT bits per clock, LSB first.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("digit_serial_addsub: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, raw, fin;
    logic [DIGIT-1:0] sum;
    logic [CW-1:0]    cnt;
    logic             a_msb, carry, c_msb, c_out, last;

    always_comb begin
        sum   = '0;
        c_out = carry;
        c_msb = carry;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c_out;
            sum[i] = a_q[i] ^ b_q[i] ^ c_out;
            c_out  = (a_q[i] & b_q[i]) | (c_out & (a_q[i] ^ b_q[i]));
        end
    end

    // Finished digits accumulate below the digit currently being summed.
    if (NDIG == 1) begin : g_one
        assign raw = sum;
    end else begin : g_many
        logic [WIDTH-DIGIT-1:0] acc;
        assign raw = {sum, acc};
        always_ff @(posedge clk)
            if (state == RUN) acc <= raw[WIDTH-1:DIGIT];
    end

`ifdef ADDSUB_SAT_EN
    logic [WIDTH-1:0] smax;
    assign smax = {WIDTH{1'b1}} >> 1;
    assign fin  = (c_msb ^ c_out) ? (a_msb ? ~smax : smax) : raw;
`else
    assign fin = raw;
`endif

    assign last = cnt == CW'(NDIG - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= fin;
                        cout   <= c_out;
                        ovf    <= c_msb ^ c_out;
                        zero   <= fin == '0;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        a_msb <= a[WIDTH-1];
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: vector table, handshake/reset sequences and random ops vs. an arithmetic model.
module tb_digit_serial_addsub;
    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst, start, sub, busy, done, cout, ovf, zero;
    logic [W-1:0] a, b, result;

    always #5 clk = ~clk;

    digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected {result, cout, ovf, zero} from signed/unsigned integer arithmetic.
    function automatic logic [10:0] model(input logic [7:0] ai, input logic [7:0] bi, input logic si);
        int sa = int'($signed(ai));
        int sb = int'($signed(bi));
        int t = si ? sa - sb : sa + sb;
        logic v = (t > 127) || (t < -128);
        logic c = si ? (ai >= bi) : (int'(ai) + int'(bi) > 255);
        logic [7:0] r = 8'(t);
`ifdef ADDSUB_SAT_EN
        if (v) r = (t > 127) ? 8'h7F : 8'h80;
`endif
        return {r, c, v, r == 8'h00};
    endfunction

    // Counts negedge samples from the accept edge until done; result must not move while busy.
    task automatic wait_done(input string nm, output int lat, output int bn);
        logic [W-1:0] prev;
        prev = result;
        lat  = 0;
        bn   = 0;
        do begin
            @(negedge clk);
            if (lat == 0) start = 1'b0;
            lat++;
            if (busy) begin
                bn++;
                chk({nm, " result stable in RUN"}, result, prev);
            end
        end while (!done && lat < 20);
        if (!done) chk({nm, " done timeout"}, done, 1'b1);
    endtask

    task automatic run_op(input string nm, input logic [7:0] ai, input logic [7:0] bi, input logic si,
                          input logic [10:0] exp);
        int lat, bn;
        @(negedge clk);
        a = ai; b = bi; sub = si; start = 1'b1;
        wait_done(nm, lat, bn);
        chk({nm, " latency"}, lat, 5);
        chk({nm, " busy cycles"}, bn, 4);
        chk({nm, " result"}, result, exp[10:3]);
        chk({nm, " cout"}, cout, exp[2]);
        chk({nm, " ovf"}, ovf, exp[1]);
        chk({nm, " zero"}, zero, exp[0]);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] a, b;
        logic       s;
        logic [7:0] r;
        logic       c, v, z;
    } vec_t;

    initial begin
        vec_t vt[6];
        int   lat, bn, nd;
        logic [10:0] e;
`ifdef ADDSUB_SAT_EN
        vt[3] = '{"pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vt[4] = '{"neg_ovf", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
`else
        vt[3] = '{"pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vt[4] = '{"neg_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
        vt[0] = '{"add",     8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
        vt[1] = '{"borrow",  8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{"sub_zero",8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[5] = '{"add_wrap",8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset flags", {cout, ovf, zero}, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].nm, vt[i].a, vt[i].b, vt[i].s, {vt[i].r, vt[i].c, vt[i].v, vt[i].z});
            @(negedge clk);
            chk({vt[i].nm, " done one pulse"}, done, 0);
            chk({vt[i].nm, " result held"}, result, vt[i].r);
        end

        // start during RUN with different operands must be ignored
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'h0F; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_start latency", lat, 5);
        chk("ignore_start result", result, 8'h33);
        chk("ignore_start cout", cout, 0);

        // back-to-back issue from the DONE cycle
        run_op("b2b_first", 8'h01, 8'h02, 1'b0, model(8'h01, 8'h02, 1'b0));
        a = 8'h40; b = 8'h05; sub = 1'b1; start = 1'b1;
        wait_done("b2b_second", lat, bn);
        chk("b2b_second latency", lat, 5);
        chk("b2b_second busy cycles", bn, 4);
        chk("b2b_second result", result, 8'h3B);
        chk("b2b_second cout", cout, 1);

        // reset during the second RUN cycle aborts the operation
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort in RUN", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort flags", {cout, ovf, zero}, 0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("abort no done", nd, 0);
        run_op("after_abort", 8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            run_op($sformatf("rand%0d %02h%s%02h", i, ra, rs ? "-" : "+", rb), ra, rb, rs, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
